// File: rtl/mem_copy_engine_if.sv
// Bus bundle for mem_copy_engine: the start/parameter handshake from the
// requester plus the single-port data memory signals (A, WD, MemWrite, RD).
// The engine connects through the master modport; the requester/memory side
// connects through the slave modport.
interface mem_copy_engine_if #(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 11
);
  logic              start;
  logic [ADDR_W-1:0] src;
  logic [ADDR_W-1:0] dst;
  logic [LEN_W-1:0]  len;
  logic              busy;
  logic              done;
  logic [31:0]       A;
  logic [31:0]       WD;
  logic              MemWrite;
  logic [31:0]       RD;

  modport master (
    input  start, src, dst, len, RD,
    output busy, done, A, WD, MemWrite
  );

  modport slave (
    output start, src, dst, len, RD,
    input  busy, done, A, WD, MemWrite
  );
endinterface

// File: rtl/mem_copy_engine.sv
// mem_copy_engine: small DMA helper that copies len consecutive 32-bit words
// from word address src to word address dst, ascending, one word per
// READ/WRITE pair (2 cycles per word). Addresses wrap modulo 2^ADDR_W.
// Optional feature macro: MEM_COPY_CHECKSUM_EN adds a 32-bit checksum output
// holding the running sum of every word written by the current job.
module mem_copy_engine #(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 11
) (
  input  logic                     clk,
  input  logic                     reset_n,
  mem_copy_engine_if.master        bus
`ifdef MEM_COPY_CHECKSUM_EN
  ,
  output logic [31:0]              checksum
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  idx_q, idx_d;
  logic [ADDR_W-1:0] a_q, a_d;
  logic              mem_write_q, mem_write_d;
  logic              done_q, done_d;
  logic [LEN_W-1:0]  idx_inc;
`ifdef MEM_COPY_CHECKSUM_EN
  logic [31:0]       checksum_q, checksum_d;
`endif

  assign idx_inc = idx_q + LEN_W'(1);

  // Next-state and next-output decode; the address for the next phase is
  // computed here so A comes straight from a flop with no path from start.
  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    dst_d       = dst_q;
    len_d       = len_q;
    idx_d       = idx_q;
    a_d         = a_q;
    mem_write_d = 1'b0;
    done_d      = 1'b0;
`ifdef MEM_COPY_CHECKSUM_EN
    checksum_d  = checksum_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          src_d = bus.src;
          dst_d = bus.dst;
          len_d = bus.len;
          idx_d = '0;
`ifdef MEM_COPY_CHECKSUM_EN
          checksum_d = '0;
`endif
          if (bus.len == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
            a_d     = '0;
          end else begin
            state_d = READ;
            a_d     = bus.src;
          end
        end
      end
      READ: begin
        state_d     = WRITE;
        a_d         = dst_q + ADDR_W'(idx_q);
        mem_write_d = 1'b1;
      end
      WRITE: begin
        idx_d = idx_inc;
`ifdef MEM_COPY_CHECKSUM_EN
        checksum_d = checksum_q + bus.RD;
`endif
        if (idx_inc == len_q) begin
          state_d = DONE;
          done_d  = 1'b1;
          a_d     = '0;
        end else begin
          state_d = READ;
          a_d     = src_q + ADDR_W'(idx_inc);
        end
      end
      DONE: begin
        state_d = IDLE;
        a_d     = '0;
      end
      default: begin
        state_d = IDLE;
        a_d     = '0;
      end
    endcase
  end

  // Single state/output register bank; async reset drops MemWrite at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      src_q       <= '0;
      dst_q       <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      a_q         <= '0;
      mem_write_q <= 1'b0;
      done_q      <= 1'b0;
`ifdef MEM_COPY_CHECKSUM_EN
      checksum_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      a_q         <= a_d;
      mem_write_q <= mem_write_d;
      done_q      <= done_d;
`ifdef MEM_COPY_CHECKSUM_EN
      checksum_q  <= checksum_d;
`endif
    end
  end

  // Outputs: WD forwards the word fetched by the preceding READ during WRITE.
  assign bus.A        = {{(32-ADDR_W){1'b0}}, a_q};
  assign bus.WD       = (state_q == WRITE) ? bus.RD : 32'd0;
  assign bus.MemWrite = mem_write_q;
  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = done_q;
`ifdef MEM_COPY_CHECKSUM_EN
  assign checksum     = checksum_q;
`endif

endmodule
